// File: rtl/spell_pkg.sv
// Shared types for the SPI memory arbiter: FSM state encoding, requester IDs
// and the command bundle latched at grant time.
package spell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic [7:0] addr;
        logic       type_data;
        logic       write;
        logic [7:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/spell_rr_arb2.sv
// Combinational two-way arbiter: round-robin on ties, or A-first when fixed_prio is set.
// gnt[0] grants port A, gnt[1] grants port B.
module spell_rr_arb2
    import spell_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed_prio || last == PORT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Shares one SPI memory engine between a code-fetch port (A) and a data port (B),
// with a forced select-low gap between transactions and a watchdog timeout.
module spell_mem_arbiter
    import spell_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int GAP_CYCLES     = 1,
    parameter bit FIXED_PRIO_A   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] addr_a,
    input  logic       type_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] addr_b,
    input  logic       type_b,
    input  logic       write_b,
    input  logic [7:0] wdata_b,
    output logic       ack_b,
    output logic [7:0] rdata,
    output logic       err,
    output logic       mem_select,
    output logic [7:0] mem_addr,
    output logic       mem_type_data,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_data_ready
);

    // One counter serves as both watchdog (BUSY) and gap timer (GAP).
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    arb_state_e       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    port_e            r_owner, w_owner_nx;
    port_e            r_last, w_last_nx;
    mem_cmd_t         r_cmd, w_cmd_nx;
    logic             r_select, w_select_nx;
    logic             r_ack_a, w_ack_a_nx;
    logic             r_ack_b, w_ack_b_nx;
    logic [7:0]       r_rdata, w_rdata_nx;
    logic             r_err, w_err_nx;
    logic [1:0]       w_gnt;

    spell_rr_arb2 u_arb (
        .req        ({req_b, req_a}),
        .last       (r_last),
        .fixed_prio (FIXED_PRIO_A),
        .gnt        (w_gnt)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_owner_nx  = r_owner;
        w_last_nx   = r_last;
        w_cmd_nx    = r_cmd;
        w_select_nx = r_select;
        w_ack_a_nx  = 1'b0;
        w_ack_b_nx  = 1'b0;
        w_rdata_nx  = 8'h00;
        w_err_nx    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt != 2'b00) begin
                    w_owner_nx  = w_gnt[0] ? PORT_A : PORT_B;
                    w_last_nx   = w_gnt[0] ? PORT_A : PORT_B;
                    if (w_gnt[0]) begin
                        // Code fetch is read-only.
                        w_cmd_nx.addr      = addr_a;
                        w_cmd_nx.type_data = type_a;
                        w_cmd_nx.write     = 1'b0;
                        w_cmd_nx.wdata     = 8'h00;
                    end else begin
                        w_cmd_nx.addr      = addr_b;
                        w_cmd_nx.type_data = type_b;
                        w_cmd_nx.write     = write_b;
                        w_cmd_nx.wdata     = wdata_b;
                    end
                    w_select_nx = 1'b1;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // data_ready takes precedence over a watchdog expiry in the same cycle.
                if (mem_data_ready || r_cnt == TO_LAST) begin
                    w_select_nx = 1'b0;
                    w_ack_a_nx  = (r_owner == PORT_A);
                    w_ack_b_nx  = (r_owner == PORT_B);
                    w_err_nx    = !mem_data_ready;
                    w_rdata_nx  = (mem_data_ready && !r_cmd.write) ? mem_rdata : 8'h00;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_GAP;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            default: begin
                w_select_nx = 1'b0;
                w_cnt_nx    = '0;
                w_state_nx  = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_owner  <= PORT_A;
            r_last   <= PORT_B;
            r_cmd    <= '0;
            r_select <= 1'b0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_rdata  <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_owner  <= w_owner_nx;
            r_last   <= w_last_nx;
            r_cmd    <= w_cmd_nx;
            r_select <= w_select_nx;
            r_ack_a  <= w_ack_a_nx;
            r_ack_b  <= w_ack_b_nx;
            r_rdata  <= w_rdata_nx;
            r_err    <= w_err_nx;
        end
    end

    assign ack_a         = r_ack_a;
    assign ack_b         = r_ack_b;
    assign rdata         = r_rdata;
    assign err           = r_err;
    assign mem_select    = r_select;
    assign mem_addr      = r_cmd.addr;
    assign mem_type_data = r_cmd.type_data;
    assign mem_write     = r_cmd.write;
    assign mem_wdata     = r_cmd.wdata;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter: dut0 uses defaults (round-robin, gap 1),
// dut1 uses fixed A priority with a 3-cycle gap. Each has its own engine model.
module tb_spell_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] addr_a, addr_b, wdata_b;
    logic       type_a, type_b, write_b;

    logic       req_a0, req_b0, ack_a0, ack_b0, err0, sel0, type0, wr0, dr0;
    logic [7:0] rdata0, maddr0, mwdata0, mrdata0;
    logic       req_a1, req_b1, ack_a1, ack_b1, err1, sel1, type1, wr1, dr1;
    logic [7:0] rdata1, maddr1, mwdata1, mrdata1;

    int         lat0, lat1;
    logic [7:0] eng_data0, eng_data1;
    int         ecnt0, ecnt1;

    int n_assert, n_fail, n, g;

    spell_mem_arbiter dut0 (
        .clk(clk), .rst(rst),
        .req_a(req_a0), .addr_a(addr_a), .type_a(type_a), .ack_a(ack_a0),
        .req_b(req_b0), .addr_b(addr_b), .type_b(type_b), .write_b(write_b),
        .wdata_b(wdata_b), .ack_b(ack_b0), .rdata(rdata0), .err(err0),
        .mem_select(sel0), .mem_addr(maddr0), .mem_type_data(type0),
        .mem_write(wr0), .mem_wdata(mwdata0), .mem_rdata(mrdata0),
        .mem_data_ready(dr0)
    );

    spell_mem_arbiter #(.TIMEOUT_CYCLES(200), .GAP_CYCLES(3), .FIXED_PRIO_A(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a1), .addr_a(addr_a), .type_a(type_a), .ack_a(ack_a1),
        .req_b(req_b1), .addr_b(addr_b), .type_b(type_b), .write_b(write_b),
        .wdata_b(wdata_b), .ack_b(ack_b1), .rdata(rdata1), .err(err1),
        .mem_select(sel1), .mem_addr(maddr1), .mem_type_data(type1),
        .mem_write(wr1), .mem_wdata(mwdata1), .mem_rdata(mrdata1),
        .mem_data_ready(dr1)
    );

    // Engine models: data_ready pulses in the lat-th cycle of select high (lat=0: never).
    assign mrdata0 = eng_data0;
    assign mrdata1 = eng_data1;

    always @(posedge clk or posedge rst) begin
        if (rst || !sel0) begin
            ecnt0 <= 0;
            dr0   <= 1'b0;
        end else begin
            ecnt0 <= ecnt0 + 1;
            dr0   <= (lat0 != 0) && (ecnt0 + 2 == lat0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst || !sel1) begin
            ecnt1 <= 0;
            dr1   <= 1'b0;
        end else begin
            ecnt1 <= ecnt1 + 1;
            dr1   <= (lat1 != 0) && (ecnt1 + 2 == lat1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for an ack on dut0; hi counts select-high cycles seen before the ack.
    task automatic wait_ack0(input int budget, output int hi);
        hi = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_a0 || ack_b0) return;
            if (sel0) hi++;
        end
        check("dut0_ack_seen", 32'(ack_a0 | ack_b0), 32'd1);
    endtask

    task automatic wait_ack1(input int budget, output int hi);
        hi = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_a1 || ack_b1) return;
            if (sel1) hi++;
        end
        check("dut1_ack_seen", 32'(ack_a1 | ack_b1), 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        req_a0 = 1'b0; req_b0 = 1'b0; req_a1 = 1'b0; req_b1 = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; wdata_b = 8'h00;
        type_a = 1'b0; type_b = 1'b0; write_b = 1'b0;
        lat0 = 0; lat1 = 0; eng_data0 = 8'h00; eng_data1 = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_select",   32'(sel0),   32'd0);
        check("rst_ack_a",    32'(ack_a0), 32'd0);
        check("rst_ack_b",    32'(ack_b0), 32'd0);
        check("rst_rdata",    32'(rdata0), 32'd0);
        check("rst_err",      32'(err0),   32'd0);
        check("rst_mem_addr", 32'(maddr0), 32'd0);
        check("rst_mem_wr",   32'(wr0),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A read of 0x12; engine answers 0xA5 in the 66th select cycle.
        addr_a = 8'h12; type_a = 1'b0; lat0 = 66; eng_data0 = 8'hA5;
        req_a0 = 1'b1;
        @(negedge clk);
        check("a_select_rise", 32'(sel0),   32'd1);
        check("a_mem_addr",    32'(maddr0), 32'h12);
        check("a_mem_type",    32'(type0),  32'd0);
        check("a_mem_write",   32'(wr0),    32'd0);
        wait_ack0(200, n);
        check("a_select_cycles", 32'(n + 1),  32'd66);
        check("a_ack_a",         32'(ack_a0), 32'd1);
        check("a_ack_b",         32'(ack_b0), 32'd0);
        check("a_rdata",         32'(rdata0), 32'hA5);
        check("a_err",           32'(err0),   32'd0);
        check("a_select_drop",   32'(sel0),   32'd0);
        req_a0 = 1'b0;
        @(negedge clk);
        check("a_ack_pulse",  32'(ack_a0), 32'd0);
        check("a_rdata_zero", 32'(rdata0), 32'd0);

        // B write 0x5C to 0x34; request fields change after grant and must not leak.
        addr_b = 8'h34; type_b = 1'b1; write_b = 1'b1; wdata_b = 8'h5C;
        lat0 = 10; eng_data0 = 8'h77;
        req_b0 = 1'b1;
        @(negedge clk);
        check("b_select",    32'(sel0),    32'd1);
        check("b_mem_addr",  32'(maddr0),  32'h34);
        check("b_mem_type",  32'(type0),   32'd1);
        check("b_mem_write", 32'(wr0),     32'd1);
        check("b_mem_wdata", 32'(mwdata0), 32'h5C);
        addr_b = 8'hFF; wdata_b = 8'h00;
        @(negedge clk);
        check("b_addr_held",  32'(maddr0),  32'h34);
        check("b_wdata_held", 32'(mwdata0), 32'h5C);
        wait_ack0(100, n);
        check("b_ack_b", 32'(ack_b0), 32'd1);
        check("b_ack_a", 32'(ack_a0), 32'd0);
        check("b_rdata", 32'(rdata0), 32'd0);
        check("b_err",   32'(err0),   32'd0);
        req_b0 = 1'b0; write_b = 1'b0;
        repeat (2) @(negedge clk);

        // Round-robin: last grant was B, so A,B,A,B,A,B; gap = 1 GAP cycle + IDLE cycle.
        lat0 = 4; eng_data0 = 8'h3C; addr_a = 8'h01; addr_b = 8'h02;
        req_a0 = 1'b1; req_b0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack0(50, n);
            check("rr_ack_a", 32'(ack_a0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ack_b", 32'(ack_b0), (k % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_rdata", 32'(rdata0), 32'h3C);
            if (k == 5) begin
                req_a0 = 1'b0; req_b0 = 1'b0;
            end else begin
                g = 1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (sel0) break;
                    g++;
                end
                check("rr_gap_low_cycles", 32'(g), 32'd2);
            end
        end

        // Fixed A priority with GAP_CYCLES=3: A,A,A then B once A lets go.
        lat1 = 4; eng_data1 = 8'h5A;
        req_a1 = 1'b1; req_b1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack1(50, n);
            check("fp_ack_a", 32'(ack_a1), 32'd1);
            check("fp_ack_b", 32'(ack_b1), 32'd0);
            if (k == 2) begin
                req_a1 = 1'b0;
            end else begin
                g = 1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (sel1) break;
                    g++;
                end
                check("fp_gap_low_cycles", 32'(g), 32'd4);
            end
        end
        wait_ack1(50, n);
        check("fp_b_after_a", 32'(ack_b1), 32'd1);
        check("fp_b_rdata",   32'(rdata1), 32'h5A);
        req_b1 = 1'b0;

        // data_ready in the last watchdog cycle: completes without error.
        repeat (3) @(negedge clk);
        lat0 = 200; eng_data0 = 8'h96;
        req_a0 = 1'b1;
        @(negedge clk);
        wait_ack0(300, n);
        check("tie_select_cycles", 32'(n + 1),  32'd200);
        check("tie_ack_a",         32'(ack_a0), 32'd1);
        check("tie_err",           32'(err0),   32'd0);
        check("tie_rdata",         32'(rdata0), 32'h96);
        req_a0 = 1'b0;

        // Engine never answers: abort after exactly 200 select-high cycles.
        repeat (3) @(negedge clk);
        lat0 = 0; eng_data0 = 8'hA5;
        req_a0 = 1'b1;
        @(negedge clk);
        wait_ack0(300, n);
        check("to_select_cycles", 32'(n + 1),  32'd200);
        check("to_ack_a",         32'(ack_a0), 32'd1);
        check("to_err",           32'(err0),   32'd1);
        check("to_rdata",         32'(rdata0), 32'd0);
        req_a0 = 1'b0;
        @(negedge clk);
        check("to_err_clear", 32'(err0), 32'd0);

        // Asynchronous reset in the middle of BUSY.
        repeat (3) @(negedge clk);
        lat0 = 0;
        req_a0 = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_rst_select", 32'(sel0), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy_select", 32'(sel0),   32'd0);
        check("rst_busy_ack_a",  32'(ack_a0), 32'd0);
        check("rst_busy_ack_b",  32'(ack_b0), 32'd0);
        req_a0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lat0 = 5; eng_data0 = 8'hC3;
        req_a0 = 1'b1;
        @(negedge clk);
        check("post_rst_select", 32'(sel0), 32'd1);
        wait_ack0(50, n);
        check("post_rst_cycles", 32'(n + 1),  32'd5);
        check("post_rst_ack_a",  32'(ack_a0), 32'd1);
        check("post_rst_rdata",  32'(rdata0), 32'hC3);
        check("post_rst_err",    32'(err0),   32'd0);
        req_a0 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
